// File: rtl/fetch_unit.sv
// RV32 instruction fetch: owns the PC, drives sync-read imem, realigns data with its PC (optional FETCH_MISALIGN_CHK_EN).
// Latency: address in cycle N, word/pc_o/valid_o in cycle N+1; one instruction per cycle.
// Backpressure: stall_i holds everything and drops imem_en_o combinationally; redirect_i overrides stall_i.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        imem_en_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic        misaligned_o,
    output logic [31:0] fetch_count_o
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q;
    logic [31:0] redirect_tgt;
    logic        redirect_bad;

    // Low address bits are dropped on load; with checking enabled a misaligned target is never loaded anyway.
    assign redirect_tgt = redirect_pc_i & ~32'h3;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misaligned_q;

    assign redirect_bad = (redirect_pc_i[1:0] != 2'b00);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            misaligned_q <= 1'b0;
        end else if (redirect_i && (state_q != ST_BOOT)) begin
            misaligned_q <= redirect_bad;
        end
    end

    assign misaligned_o = misaligned_q;
`else
    assign redirect_bad = 1'b0;
    assign misaligned_o = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_i) begin
                    valid_d = 1'b0;
                    if (redirect_bad) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = redirect_tgt;
                    end
                end else if (!stall_i) begin
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    if (halt_i) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                valid_d = 1'b0;
                if (redirect_i && !redirect_bad) begin
                    pc_d    = redirect_tgt;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    // An instruction counts as delivered on the edge that moves it out of IF/ID.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= 32'd0;
        end else if (valid_q && !stall_i) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign imem_en_o     = (state_q == ST_RUN) && !stall_i;
    assign imem_addr_o   = pc_q;
    assign instr_o       = valid_q ? imem_rdata_i : NOP_INSTR;
    assign pc_o          = pc_out_q;
    assign pc_plus4_o    = pc_out_q + 32'd4;
    assign valid_o       = valid_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model and per-cycle compare.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        boot;
        logic        halted;
        logic        valid;
        logic        mis;
        logic [31:0] pc;
        logic [31:0] opc;
        logic [31:0] cnt;
    } mstate_t;

    localparam mstate_t MS_RST = '{boot: 1'b1, halted: 1'b0, valid: 1'b0, mis: 1'b0,
                                   pc: 32'h0, opc: 32'h0, cnt: 32'h0};

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr, pc, pc4, cnt;
    logic        valid, mis;

    int n_pass = 0;
    int n_total = 0;
    mstate_t ms = MS_RST;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .resetn(resetn), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(rpc), .halt_i(halt), .imem_en_o(imem_en), .imem_addr_o(imem_addr),
        .imem_rdata_i(imem_rdata), .instr_o(instr), .pc_o(pc), .pc_plus4_o(pc4),
        .valid_o(valid), .misaligned_o(mis), .fetch_count_o(cnt)
    );

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A3;
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= memw(imem_addr);
    end

    function automatic mstate_t model_next(input mstate_t s, input logic st, input logic rd,
                                           input logic hl, input logic [31:0] tgt);
        mstate_t n = s;
        if (s.valid && !st) n.cnt = s.cnt + 32'd1;
        if (s.boot) begin
            n.boot = 1'b0;
        end else if (rd) begin
            n.valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            if (tgt % 4 != 0) begin
                n.mis    = 1'b1;
                n.halted = 1'b1;
            end else
`endif
            begin
                n.pc     = tgt - (tgt % 4);
                n.mis    = 1'b0;
                n.halted = 1'b0;
            end
        end else if (s.halted) begin
            n.valid = 1'b0;
        end else if (!st) begin
            n.opc    = s.pc;
            n.valid  = 1'b1;
            n.pc     = s.pc + 32'd4;
            n.halted = hl;
        end
        return n;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) ms <= MS_RST;
        else         ms <= model_next(ms, stall, redirect, halt, rpc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            chk("m_valid",    32'(valid),   32'(ms.valid));
            chk("m_pc_o",     pc,           ms.opc);
            chk("m_pc_plus4", pc4,          ms.opc + 32'd4);
            chk("m_instr",    instr,        ms.valid ? memw(ms.opc) : NOP);
            chk("m_imem_en",  32'(imem_en), 32'(!ms.boot && !ms.halted && !stall));
            chk("m_imem_addr", imem_addr,   ms.pc);
            chk("m_count",    cnt,          ms.cnt);
            chk("m_misalign", 32'(mis),     32'(ms.mis));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic redir(input logic [31:0] tgt);
        redirect = 1'b1;
        rpc = tgt;
        step();
        redirect = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        resetn = 1'b1;
        chk("rst_valid",  32'(valid),   32'd0);
        chk("rst_pc",     pc,           32'h0);
        chk("rst_pc4",    pc4,          32'h4);
        chk("rst_instr",  instr,        NOP);
        chk("rst_en",     32'(imem_en), 32'd0);
        chk("rst_count",  cnt,          32'd0);
        chk("rst_mis",    32'(mis),     32'd0);

        // Requests during BOOT must be ignored.
        redirect = 1'b1; rpc = 32'h80; halt = 1'b1;
        step();
        redirect = 1'b0; halt = 1'b0;
        chk("boot_valid", 32'(valid),   32'd0);
        chk("boot_en",    32'(imem_en), 32'd1);
        step();
        chk("first_pc",    pc,          32'h0);
        chk("first_valid", 32'(valid),  32'd1);
        chk("first_instr", instr,       32'h5A5A_A5A3);
        step();
        chk("seq_pc4",   pc,  32'h4);
        chk("seq_cnt1",  cnt, 32'd1);
        step();
        chk("seq_pc8",    pc,    32'h8);
        chk("seq_instr8", instr, 32'h5A5A_A5AB);
        chk("seq_cnt2",   cnt,   32'd2);

        stall = 1'b1;
        #1;
        chk("stall_en", 32'(imem_en), 32'd0);
        step(2);
        chk("stall_pc",    pc,    32'h8);
        chk("stall_instr", instr, 32'h5A5A_A5AB);
        chk("stall_cnt",   cnt,   32'd2);
        step();
        stall = 1'b0;
        step();
        chk("post_stall_pc",  pc,  32'hC);
        chk("post_stall_cnt", cnt, 32'd3);
        step();
        chk("pre_redir_pc", pc, 32'h10);

        redir(32'h40);
        chk("redir_bubble", 32'(valid), 32'd0);
        chk("redir_cnt",    cnt,        32'd5);
        step();
        chk("redir_pc",    pc,    32'h40);
        chk("redir_instr", instr, 32'h5A5A_A5E3);
        chk("redir_valid", 32'(valid), 32'd1);

        redir(32'h10);
        step();
        stall = 1'b1;
        redir(32'h40);
        stall = 1'b0;
        chk("redir_stall_bubble", 32'(valid), 32'd0);
        step();
        chk("redir_stall_pc",    pc,         32'h40);
        chk("redir_stall_valid", 32'(valid), 32'd1);

        redir(32'h1C);
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("halt_last_pc",    pc,         32'h20);
        chk("halt_last_valid", 32'(valid), 32'd1);
        step();
        chk("halt_valid", 32'(valid),   32'd0);
        chk("halt_en",    32'(imem_en), 32'd0);
        stall = 1'b1; halt = 1'b1;
        step(3);
        stall = 1'b0; halt = 1'b0;
        chk("halt_hold_valid", 32'(valid), 32'd0);
        chk("halt_hold_addr",  imem_addr,  32'h24);
        redir(32'h100);
        chk("resume_bubble", 32'(valid), 32'd0);
        step();
        chk("resume_pc",    pc,         32'h100);
        chk("resume_valid", 32'(valid), 32'd1);

        halt = 1'b1;
        redir(32'h200);
        halt = 1'b0;
        step();
        chk("redir_halt_pc", pc, 32'h200);
        step();
        chk("redir_halt_run_pc",    pc,         32'h204);
        chk("redir_halt_run_valid", 32'(valid), 32'd1);

        redir(32'h42);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_set", 32'(mis), 32'd1);
        step(2);
        chk("mis_halt_valid", 32'(valid),   32'd0);
        chk("mis_halt_en",    32'(imem_en), 32'd0);
        redir(32'h80);
        chk("mis_clr", 32'(mis), 32'd0);
        step();
        chk("mis_resume_pc", pc, 32'h80);
`else
        chk("mis_tied", 32'(mis), 32'd0);
        step();
        chk("mis_align_pc",    pc,         32'h40);
        chk("mis_align_valid", 32'(valid), 32'd1);
`endif

        redir(32'hFFFF_FFFC);
        step();
        chk("wrap_pc",  pc,  32'hFFFF_FFFC);
        chk("wrap_pc4", pc4, 32'h0);
        step();
        chk("wrap_next_pc",    pc,         32'h0);
        chk("wrap_next_valid", 32'(valid), 32'd1);

        step(2);
        resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(valid),   32'd0);
        chk("arst_pc",    pc,           32'h0);
        chk("arst_cnt",   cnt,          32'd0);
        chk("arst_en",    32'(imem_en), 32'd0);
        chk("arst_instr", instr,        NOP);
        step(2);
        resetn = 1'b1;
        step(2);
        chk("rerun_pc",    pc,         32'h0);
        chk("rerun_valid", 32'(valid), 32'd1);
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
